dnn_layer_seq: RTL

Parametrised, time-multiplexed fully-connected layer for the DNN datapath. It generalises the fixed 4-input / 4-output single-cycle MAC layer to N_IN inputs and N_OUT neurons. One input is consumed per cycle across N_OUT parallel MAC lanes, so multiplier count scales with N_OUT only. It sits between the input/weight staging logic and the next layer, with the same in_ready / mac_ready handshake style and an optional compiled-in ReLU.

---
 rtl/dnn_pkg.sv | 18 +
 rtl/dnn_layer_seq_if.sv | 26 ++
 rtl/dnn_mac_lane.sv | 65 ++++++
 rtl/dnn_layer_seq.sv | 124 ++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared definitions for the DNN datapath layers: FSM state type,
// default operand/accumulator widths and the accumulator width check.
package dnn_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } dnn_state_e;

  localparam int DNN_IN_SIZE  = 7;
  localparam int DNN_OUT_SIZE = 17;

  // Narrowest accumulator that can hold n_in full-precision products without wrapping.
  function automatic int min_out_size(input int in_size, input int n_in);
    return 2 * in_size + $clog2(n_in);
  endfunction

endpackage

// File: rtl/dnn_layer_seq_if.sv
// Start/operand/result bundle between the staging logic and dnn_layer_seq.
interface dnn_layer_seq_if #(
  parameter int IN_SIZE  = 7,
  parameter int OUT_SIZE = 17,
  parameter int N_IN     = 4,
  parameter int N_OUT    = 4
) ();

  logic                            in_ready;
  logic [N_IN*IN_SIZE-1:0]         x_flat;
  logic [N_IN*N_OUT*IN_SIZE-1:0]   w_flat;
  logic [N_OUT*OUT_SIZE-1:0]       out_flat;
  logic                            busy;
  logic                            mac_ready;

  modport master (
    output in_ready, x_flat, w_flat,
    input  out_flat, busy, mac_ready
  );

  modport slave (
    input  in_ready, x_flat, w_flat,
    output out_flat, busy, mac_ready
  );

endinterface

// File: rtl/dnn_mac_lane.sv
// One neuron lane: signed multiply-accumulate with a registered result.
// Compile with DNN_RELU_EN defined to clamp negative results to zero on load.
module dnn_mac_lane
  import dnn_pkg::*;
#(
  parameter int IN_SIZE  = DNN_IN_SIZE,
  parameter int OUT_SIZE = DNN_OUT_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       enable,
  input  logic                       last,
  input  logic signed [IN_SIZE-1:0]  x,
  input  logic signed [IN_SIZE-1:0]  w,
  output logic signed [OUT_SIZE-1:0] result
);

  logic signed [2*IN_SIZE-1:0] prod_s;
  logic signed [OUT_SIZE-1:0]  prod_ext_s;
  logic signed [OUT_SIZE-1:0]  sum_s;
  logic signed [OUT_SIZE-1:0]  load_s;
  logic signed [OUT_SIZE-1:0]  acc_r;
  logic signed [OUT_SIZE-1:0]  result_r;

  // Product, running sum and the value loaded into the result on the last term
  always_comb begin
    prod_s     = (2*IN_SIZE)'(x) * (2*IN_SIZE)'(w);
    prod_ext_s = OUT_SIZE'(prod_s);
    sum_s      = acc_r + prod_ext_s;
`ifdef DNN_RELU_EN
    if (sum_s[OUT_SIZE-1]) begin
      load_s = {OUT_SIZE{1'b0}};
    end else begin
      load_s = sum_s;
    end
`else
    load_s = sum_s;
`endif
  end

  // Accumulator and result registers; the sum wraps modulo 2^OUT_SIZE
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r    <= {OUT_SIZE{1'b0}};
      result_r <= {OUT_SIZE{1'b0}};
    end else begin
      if (clear) begin
        acc_r <= {OUT_SIZE{1'b0}};
      end else if (enable) begin
        acc_r <= sum_s;
      end else begin
        acc_r <= acc_r;
      end
      if (enable && last) begin
        result_r <= load_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign result = result_r;

endmodule

// File: rtl/dnn_layer_seq.sv
// Time-multiplexed fully-connected layer: one input term per cycle across N_OUT lanes.
// Optional ReLU on the outputs is enabled by defining DNN_RELU_EN.
module dnn_layer_seq
  import dnn_pkg::*;
#(
  parameter int IN_SIZE  = DNN_IN_SIZE,
  parameter int OUT_SIZE = DNN_OUT_SIZE,
  parameter int N_IN     = 4,
  parameter int N_OUT    = 4
) (
  input logic           clk,
  input logic           rst,
  dnn_layer_seq_if.slave bus
);

  localparam int            KW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);

  if (N_IN < 1 || N_OUT < 1) begin : g_dim_err
    $error("dnn_layer_seq: N_IN and N_OUT must be at least 1");
  end
  if (OUT_SIZE < min_out_size(IN_SIZE, N_IN)) begin : g_width_err
    $error("dnn_layer_seq: OUT_SIZE too narrow for IN_SIZE/N_IN");
  end

  dnn_state_e                    state_r;
  dnn_state_e                    state_next_s;
  logic [KW-1:0]                 k_r;
  logic [KW-1:0]                 k_next_s;
  logic [N_IN*IN_SIZE-1:0]       x_r;
  logic [N_IN*N_OUT*IN_SIZE-1:0] w_r;
  logic                          capture_s;
  logic                          enable_s;
  logic                          last_s;
  logic                          busy_r;
  logic                          mac_ready_r;
  logic signed [IN_SIZE-1:0]     x_sel_s;
  logic [N_OUT*OUT_SIZE-1:0]     out_s;

  // Next-state, term counter and lane control decode
  always_comb begin
    state_next_s = state_r;
    k_next_s     = k_r;
    capture_s    = 1'b0;
    enable_s     = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_ready) begin
          state_next_s = ACC;
          k_next_s     = {KW{1'b0}};
          capture_s    = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACC: begin
        enable_s = 1'b1;
        if (k_r == K_LAST) begin
          last_s       = 1'b1;
          state_next_s = IDLE;
          k_next_s     = {KW{1'b0}};
        end else begin
          k_next_s = k_r + KW'(1);
        end
      end
      default: begin
        state_next_s = IDLE;
        k_next_s     = {KW{1'b0}};
      end
    endcase
  end

  // FSM state, counter, operand capture and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      k_r         <= {KW{1'b0}};
      x_r         <= {(N_IN*IN_SIZE){1'b0}};
      w_r         <= {(N_IN*N_OUT*IN_SIZE){1'b0}};
      busy_r      <= 1'b0;
      mac_ready_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      k_r     <= k_next_s;
      if (capture_s) begin
        x_r <= bus.x_flat;
        w_r <= bus.w_flat;
      end
      busy_r      <= (state_next_s == ACC);
      mac_ready_r <= last_s;
    end
  end

  // Select the current input term shared by every lane
  always_comb begin
    x_sel_s = x_r[int'(k_r)*IN_SIZE +: IN_SIZE];
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_lane
    logic signed [IN_SIZE-1:0] w_sel_s;

    assign w_sel_s = w_r[(int'(k_r)*N_OUT + j)*IN_SIZE +: IN_SIZE];

    dnn_mac_lane #(
      .IN_SIZE  (IN_SIZE),
      .OUT_SIZE (OUT_SIZE)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clear  (capture_s),
      .enable (enable_s),
      .last   (last_s),
      .x      (x_sel_s),
      .w      (w_sel_s),
      .result (out_s[j*OUT_SIZE +: OUT_SIZE])
    );
  end

  assign bus.out_flat  = out_s;
  assign bus.busy      = busy_r;
  assign bus.mac_ready = mac_ready_r;

endmodule
